btn_event: RTL and testbench
============================

BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, event FIFO depth; power of two, 2..16.
REQ-002 SHALL provide parameter REPEAT_DELAY, default 100, ticks a button is held before the first repeat event.
REQ-003 SHALL provide parameter REPEAT_PERIOD, default 40, ticks between later repeat events.
REQ-004 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tick  input  1  one-cycle slow strobe, the same strobe that paces the debouncers.
REQ-007 SHALL have port btn  input  4  debounced buttons, active-high: [0]=up, [1]=down, [2]=left, [3]=right.
REQ-008 SHALL have port evt_valid  output  1  FIFO non-empty; evt_code is valid.
REQ-009 SHALL have port evt_code  output  2  head event: button index 0..3.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts the head event when evt_valid and evt_ready are both high.
REQ-011 SHALL have port evt_drop  output  1  one-cycle pulse when an event is discarded because the FIFO is full.

Function
REQ-012 SHALL register btn into btn_q every clk; rise[i] = btn[i] & ~btn_q[i].
REQ-013 SHALL generate one press event per cycle in which any rise bit is set; lowest set index wins; other simultaneous rises are discarded silently.
REQ-014 SHALL write the event into the FIFO on the clock edge where the rise is first seen; evt_valid rises one cycle after btn is first sampled high, when the FIFO was empty.
REQ-015 SHALL pop the head on (evt_valid & evt_ready); evt_code shows the next entry in the following cycle; ready while !evt_valid has no effect.
REQ-016 SHALL preserve event order (first in, first out); occupancy counter width is log2(DEPTH)+1; read and write pointers wrap modulo DEPTH.
REQ-017 SHALL, when full with no pop in the same cycle, drop the new event, leave FIFO contents unchanged, and pulse evt_drop for 1 cycle.
REQ-018 SHALL, when full with a pop in the same cycle, accept the push; occupancy stays DEPTH and evt_drop stays 0.
REQ-019 SHALL, when empty with a push in the same cycle, perform no pop; the event becomes head in the next cycle.
REQ-020 SHALL hold evt_code at its last value while evt_valid=0.
REQ-021 SHALL record the index of the most recent press event as the held button; a release of a non-held button has no effect.

Reset
REQ-022 SHALL on rst: empty the FIFO, discarding any contents; evt_valid=0, evt_code=0, evt_drop=0, btn_q=0, repeat state IDLE with counter 0.
REQ-023 SHALL, because btn_q resets to 0, emit one press event after reset deasserts for a button held through reset.
REQ-024 SHALL let rst override all simultaneous push, pop and tick activity.

Configuration
REQ-025 SHALL compile the auto-repeat logic only when macro BTN_AUTOREPEAT_EN is defined.
REQ-026 SHALL with BTN_AUTOREPEAT_EN run repeat FSM IDLE->DELAY->REPEAT:
  - IDLE->DELAY on a press event; counter cleared.
  - DELAY: counter increments on tick; at REPEAT_DELAY ticks, emit a repeat event (held index, same FIFO path) -> REPEAT, counter cleared.
  - REPEAT: emit a repeat event every REPEAT_PERIOD ticks.
  - Release of the held button -> IDLE.
  - A new press restarts DELAY with the new index.
  - A repeat coinciding with a press is discarded; the press wins.
REQ-027 SHALL without BTN_AUTOREPEAT_EN emit exactly one event per press regardless of hold time; no repeat counter is instantiated.

Verification
REQ-028 SHALL cover single press: btn=0001 for 3 clk -> evt_valid one cycle later, evt_code=0, exactly one event; ready=1 -> empty next cycle.
REQ-029 SHALL cover simultaneous rise: btn 0000->1100 -> one event, code=2; no evt_drop.
REQ-030 SHALL cover overflow: DEPTH=4, ready=0, presses of buttons 3,2,1,0,3 -> FIFO holds 3,2,1,0; fifth press pulses evt_drop; draining yields 3,2,1,0 in order.
REQ-031 SHALL cover full with pop: FIFO full, ready=1, press in the same cycle -> push accepted, evt_drop=0, occupancy stays 4.
REQ-032 SHALL cover repeat (macro on, DELAY=3, PERIOD=2): hold btn[1] for 9 ticks -> events at press, tick 3, tick 5, tick 7, tick 9 (code=1); release -> no more events; macro off -> single event.
REQ-033 SHALL cover reset mid-operation: 2 entries queued, rst pulse -> evt_valid=0 next cycle; held btn[0] -> one new event, code=0, after rst deasserts.

Source files
------------

// File: rtl/btn_event.sv
// Button press-event queue: turns rising edges on four debounced buttons into events held in a small FIFO.
// Latency: an event is visible on evt_valid/evt_code one clk after the button is first sampled high.
// Backpressure: valid/ready pop; a full FIFO with no pop in the same cycle drops the new event and pulses evt_drop.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   tick               slow strobe that paces the auto-repeat counter
//   btn[3:0]           debounced buttons: [0]=up [1]=down [2]=left [3]=right
//   evt_valid/evt_code head of the event FIFO (button index 0..3)
//   evt_ready          consumer accepts the head when evt_valid is also high
//   evt_drop           one-cycle pulse, registered, after an event was discarded on a full FIFO
//
// Optional feature: define BTN_AUTOREPEAT_EN to build the hold-to-repeat FSM.
// Without it every press gives exactly one event and tick is ignored.

module btn_event #(
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_PERIOD = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] btn,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // ---------------------------------------------------------------------------
  // Edge detection and press priority
  // ---------------------------------------------------------------------------
  logic [3:0] btn_q, btn_d;
  logic [3:0] rise;
  logic       press_vld;
  logic [1:0] press_idx;

  always_comb begin
    btn_d     = btn;
    rise      = btn & ~btn_q;
    press_vld = |rise;
    press_idx = 2'd0;
    // Scan from the top so the lowest set index is the one left standing.
    for (int i = 3; i >= 0; i--) begin
      if (rise[i]) press_idx = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
  logic       rep_vld;
  logic [1:0] rep_code;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_REPEAT
  } rep_state_t;

  rep_state_t state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [1:0]    held_q, held_d;
  logic [RW-1:0] cnt_lim;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    rep_vld  = 1'b0;
    rep_code = held_q;
    // Counter holds ticks-minus-one, so the event fires on the tick that reaches the limit.
    cnt_lim  = (state_q == R_DELAY) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);

    if (press_vld) begin
      // A fresh press always restarts the delay; any repeat due this cycle is lost.
      state_d = R_DELAY;
      cnt_d   = '0;
      held_d  = press_idx;
    end else begin
      case (state_q)
        R_DELAY, R_REPEAT: begin
          if (!btn[held_q]) begin
            state_d = R_IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_q == cnt_lim) begin
              rep_vld = 1'b1;
              state_d = R_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= R_IDLE;
      cnt_q   <= '0;
      held_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end
`else
  logic unused_tick;

  assign unused_tick = tick;
  assign rep_vld     = 1'b0;
  assign rep_code    = 2'd0;
`endif

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    code_q, code_d;
  logic          drop_q, drop_d;

  logic          push_vld;
  logic [1:0]    push_code;
  logic          pop;
  logic          full;
  logic          push_ok;

  always_comb begin
    push_vld  = press_vld | rep_vld;
    push_code = press_vld ? press_idx : rep_code;

    pop     = (count_q != '0) & evt_ready;
    full    = (count_q == CW'(DEPTH));
    // Full is still writable when the head leaves in the same cycle.
    push_ok = push_vld & (~full | pop);
    drop_d  = push_vld & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // evt_code is a register so it can hold its last value while empty.
    // When the next head is the entry being written this cycle, take it from
    // the push path because mem_q does not hold it yet.
    code_d = code_q;
    if (count_d != '0) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
        code_d = push_code;
      end else begin
        code_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      code_q   <= 2'd0;
      drop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 2'd0;
      end
    end else begin
      btn_q    <= btn_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      code_q   <= code_d;
      drop_q   <= drop_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_code  = code_q;
  assign evt_drop  = drop_q;

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event: directed scenarios followed by random
// button/tick/ready/reset traffic, all compared every cycle against a
// queue-based reference model.

module tb_btn_event;

  localparam int DEPTH  = 4;
  localparam int RDELAY = 3;
  localparam int RPER   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] btn;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_drop;

  int checks = 0;
  int errors = 0;

  btn_event #(
    .DEPTH        (DEPTH),
    .REPEAT_DELAY (RDELAY),
    .REPEAT_PERIOD(RPER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn      (btn),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_ready(evt_ready),
    .evt_drop (evt_drop)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of button indices plus "ticks held since press".
  // ---------------------------------------------------------------------------
  int         q[$];
  logic [3:0] m_prev      = 4'd0;
  logic [1:0] m_last_code = 2'd0;
  logic       m_drop      = 1'b0;
  bit         m_active    = 1'b0;
  int         m_held      = 0;
  int         m_ticks     = 0;

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_step();
    logic [3:0] rise;
    bit         push;
    bit         pop;
    int         code;
    push = 1'b0;
    code = 0;
    if (rst) begin
      q.delete();
      m_prev      = 4'd0;
      m_last_code = 2'd0;
      m_drop      = 1'b0;
      m_active    = 1'b0;
      m_ticks     = 0;
      return;
    end
    rise = btn & ~m_prev;
    if (rise != 4'd0) begin
      push     = 1'b1;
      code     = lowest_set(rise);
      m_held   = code;
      m_active = 1'b1;
      m_ticks  = 0;
    end else if (m_active) begin
      if (!btn[m_held]) begin
        m_active = 1'b0;
      end else if (tick) begin
        m_ticks++;
`ifdef BTN_AUTOREPEAT_EN
        // Repeats fall on held-tick counts DELAY, DELAY+PERIOD, DELAY+2*PERIOD, ...
        if (m_ticks >= RDELAY && ((m_ticks - RDELAY) % RPER) == 0) begin
          push = 1'b1;
          code = m_held;
        end
`endif
      end
    end
    pop    = (q.size() > 0) && evt_ready;
    m_drop = push && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !m_drop) q.push_back(code);
    if (q.size() > 0) m_last_code = 2'(q[0]);
    m_prev = btn;
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: update model from the inputs now applied, clock the DUT,
  // then compare all outputs away from the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, {1'b0, evt_valid}, {1'b0, q.size() > 0});
    chk({tag, ".code"},  evt_code, m_last_code);
    chk({tag, ".drop"},  {1'b0, evt_drop}, {1'b0, m_drop});
  endtask

  int seen;

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    btn       = 4'd0;
    evt_ready = 1'b0;

    // Reset state
    step("reset");
    step("reset");
    chk("reset_valid_const", {1'b0, evt_valid}, 2'd0);
    chk("reset_code_const", evt_code, 2'd0);
    rst = 1'b0;
    step("idle");

    // Single press of up, held three cycles, then popped
    btn = 4'b0001;
    step("single");
    chk("single_code_const", evt_code, 2'd0);
    chk("single_valid_const", {1'b0, evt_valid}, 2'd1);
    step("single");
    step("single");
    evt_ready = 1'b1;
    step("single_pop");
    chk("single_empty_const", {1'b0, evt_valid}, 2'd0);
    btn = 4'b0000;
    step("single_rel");

    // Simultaneous rise of left and right: left (2) wins
    evt_ready = 1'b0;
    btn = 4'b1100;
    step("simul");
    chk("simul_code_const", evt_code, 2'd2);
    evt_ready = 1'b1;
    step("simul");
    step("simul");
    btn = 4'b0000;
    step("simul_rel");

    // Overflow: 3,2,1,0 fill, second 3 is dropped, drain in order
    evt_ready = 1'b0;
    btn = 4'b1000; step("ovf");
    btn = 4'b0100; step("ovf");
    btn = 4'b0010; step("ovf");
    btn = 4'b0001; step("ovf");
    btn = 4'b1000; step("ovf_drop");
    chk("ovf_drop_const", {1'b0, evt_drop}, 2'd1);
    btn = 4'b0000; step("ovf");
    chk("ovf_drop_clear", {1'b0, evt_drop}, 2'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("ovf_drain");

    // Full with a pop in the same cycle: push accepted, no drop
    evt_ready = 1'b0;
    btn = 4'b1000; step("fullpop");
    btn = 4'b0100; step("fullpop");
    btn = 4'b0010; step("fullpop");
    btn = 4'b0001; step("fullpop");
    btn = 4'b0000; step("fullpop");
    evt_ready = 1'b1;
    btn = 4'b1000; step("fullpop_push");
    chk("fullpop_nodrop", {1'b0, evt_drop}, 2'd0);
    btn = 4'b0000;
    for (int i = 0; i < 6; i++) step("fullpop_drain");

    // Hold down for nine ticks, then release and keep ticking
    seen = 0;
    evt_ready = 1'b1;
    btn = 4'b0010;
    step("rep_press");
    if (evt_valid) seen++;
    for (int t = 0; t < 9; t++) begin
      tick = 1'b1; step("rep_tick");
      if (evt_valid) seen++;
      tick = 1'b0; step("rep_gap");
      if (evt_valid) seen++;
      step("rep_gap");
      if (evt_valid) seen++;
    end
    btn = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      tick = 1'b1; step("rep_rel");
      if (evt_valid) seen++;
      tick = 1'b0; step("rep_rel");
      if (evt_valid) seen++;
    end
`ifdef BTN_AUTOREPEAT_EN
    chk("rep_event_count", 2'(seen), 2'(5));
`else
    chk("rep_event_count", 2'(seen), 2'(1));
`endif

    // Reset with two entries queued and up held through reset
    evt_ready = 1'b0;
    btn = 4'b0001; step("rstmid");
    btn = 4'b0011; step("rstmid");
    rst = 1'b1;    step("rstmid_rst");
    chk("rstmid_valid_const", {1'b0, evt_valid}, 2'd0);
    rst = 1'b0;    step("rstmid_after");
    chk("rstmid_code_const", evt_code, 2'd0);
    chk("rstmid_valid_after", {1'b0, evt_valid}, 2'd1);
    evt_ready = 1'b1;
    step("rstmid_pop");
    btn = 4'b0000;
    step("rstmid_rel");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      end
      tick      = ($urandom_range(0, 3) == 0);
      evt_ready = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      step("rand");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
